// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: command sequencer in front of the combinational alu.
// Queues (opcode, a, b) requests in a small FIFO, issues them one at a time on
// registered alu inputs, captures result/flags one cycle later and presents
// them on a valid/ready response port until accepted.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | nothing in flight; waiting for the FIFO to hold a command
//   EXEC  | alu inputs stable this cycle; result captured at the edge
//   RESP  | response held valid until the consumer accepts it
module alu_cmd_seq #(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [3:0]                 cmd_opcode_i,
  input  logic [N-1:0]               cmd_a_i,
  input  logic [N-1:0]               cmd_b_i,
  output logic [3:0]                 alu_opcode_o,
  output logic [N-1:0]               alu_a_o,
  output logic [N-1:0]               alu_b_o,
  input  logic [N-1:0]               alu_result_i,
  input  logic                       alu_c_i,
  input  logic                       alu_z_i,
  input  logic                       alu_n_i,
  input  logic                       alu_v_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [N-1:0]               rsp_result_o,
  output logic [3:0]                 rsp_flags_o,
  output logic                       busy_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 4 + 2 * N;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q;
  logic [ENT_W-1:0]   fifo_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [3:0]         alu_opcode_q;
  logic [N-1:0]       alu_a_q;
  logic [N-1:0]       alu_b_q;
  logic               rsp_valid_q;
  logic [N-1:0]       rsp_result_q;
  logic [3:0]         rsp_flags_q;
  logic               busy_q;

  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               rsp_accept;
  logic [ENT_W-1:0]   head;
  logic [3:0]         head_opcode;
  logic [N-1:0]       head_a;
  logic [N-1:0]       head_b;

  // FIFO status and handshake qualification; ready depends on occupancy only,
  // so a full FIFO refuses a push even when a pop happens in the same cycle.
  always_comb begin
    fifo_full   = (count_q == CNT_W'(DEPTH));
    fifo_empty  = (count_q == '0);
    push        = cmd_valid_i && !fifo_full;
    rsp_accept  = (state_q == RESP) && rsp_valid_q && rsp_ready_i;
    pop         = !fifo_empty &&
                  ((state_q == IDLE) || rsp_accept);
    head        = fifo_mem[rd_ptr_q];
    head_opcode = head[ENT_W-1 -: 4];
    head_a      = head[2*N-1 -: N];
    head_b      = head[N-1:0];
  end

  // Next pointer/occupancy values; pointers wrap naturally at DEPTH (power of two).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= {cmd_opcode_i, cmd_a_i, cmd_b_i};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Sequencer FSM with registered alu and response outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            alu_opcode_q <= head_opcode;
            alu_a_q      <= head_a;
            alu_b_q      <= head_b;
            busy_q       <= 1'b1;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q <= alu_result_i;
          rsp_flags_q  <= {alu_n_i, alu_z_i, alu_c_i, alu_v_i};
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_accept) begin
            rsp_valid_q <= 1'b0;
            if (!fifo_empty) begin
              // Chain straight into the next command to sustain one response per two cycles.
              alu_opcode_q <= head_opcode;
              alu_a_q      <= head_a;
              alu_b_q      <= head_b;
              state_q      <= EXEC;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o  = !fifo_full;
  assign count_o      = count_q;
  assign alu_opcode_o = alu_opcode_q;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_flags_o  = rsp_flags_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Bench for alu_cmd_seq: a small alu model on the alu side, a queue scoreboard
// of accepted commands on the response side, directed scenarios plus random traffic.
module tb_alu_cmd_seq;

  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cmd_valid_i;
  logic         cmd_ready_o;
  logic [3:0]   cmd_opcode_i;
  logic [N-1:0] cmd_a_i;
  logic [N-1:0] cmd_b_i;
  logic [3:0]   alu_opcode_o;
  logic [N-1:0] alu_a_o;
  logic [N-1:0] alu_b_o;
  logic [N-1:0] alu_result_i;
  logic         alu_c_i, alu_z_i, alu_n_i, alu_v_i;
  logic         rsp_valid_o;
  logic         rsp_ready_i;
  logic [N-1:0] rsp_result_o;
  logic [3:0]   rsp_flags_o;
  logic         busy_o;
  logic [$clog2(DEPTH):0] count_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q [$];   // {flags, result} of accepted commands, in order

  alu_cmd_seq #(.N(N), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_opcode_i(cmd_opcode_i), .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i),
    .alu_opcode_o(alu_opcode_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_result_i(alu_result_i), .alu_c_i(alu_c_i), .alu_z_i(alu_z_i),
    .alu_n_i(alu_n_i), .alu_v_i(alu_v_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_flags_o(rsp_flags_o),
    .busy_o(busy_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural alu: returns {n,z,c,v,result}.
  function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    int ai, bi, sa, sb, sr, r;
    logic c, v;
    ai = int'(a); bi = int'(b);
    sa = (ai > 7) ? ai - 16 : ai;
    sb = (bi > 7) ? bi - 16 : bi;
    c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin r = ai + bi; c = (r > 15); sr = sa + sb; v = (sr > 7) || (sr < -8); end
      4'd1: begin r = ai - bi; c = (ai < bi); sr = sa - sb; v = (sr > 7) || (sr < -8); end
      4'd2: r = int'(a & b);
      4'd3: r = int'(a | b);
      default: r = int'(a ^ b);
    endcase
    r = r & 15;
    return {r[3], (r == 0), c, v, r[3:0]};
  endfunction

  always_comb begin
    logic [7:0] o;
    o = alu_ref(alu_opcode_o, alu_a_o, alu_b_o);
    {alu_n_i, alu_z_i, alu_c_i, alu_v_i} = o[7:4];
    alu_result_i = o[3:0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: inputs change 1ns after the rising edge, so the falling edge
  // sees exactly what the next rising edge will act on.
  always @(negedge clk_i) begin
    if (rst_i) begin
      exp_q.delete();
    end else begin
      if (rsp_valid_o && rsp_ready_i) begin
        if (exp_q.size() == 0) chk("stale_rsp", 32'(rsp_valid_o), 32'd0);
        else begin
          chk("sb_result", 32'(rsp_result_o), 32'(exp_q[0][3:0]));
          chk("sb_flags",  32'(rsp_flags_o),  32'(exp_q[0][7:4]));
          void'(exp_q.pop_front());
        end
      end
      if (cmd_valid_i && cmd_ready_o)
        exp_q.push_back(alu_ref(cmd_opcode_i, cmd_a_i, cmd_b_i));
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_cmd(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    int n;
    cmd_opcode_i = op; cmd_a_i = a; cmd_b_i = b; cmd_valid_i = 1'b1;
    n = 0;
    while (!cmd_ready_o && n < 50) begin tick(); n++; end
    if (!cmd_ready_o) chk("push_timeout", 32'(cmd_ready_o), 32'd1);
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!rsp_valid_o && cycles < 30) begin tick(); cycles++; end
    if (!rsp_valid_o) chk("valid_timeout", 32'(rsp_valid_o), 32'd1);
  endtask

  task automatic drain();
    int n;
    cmd_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    n = 0;
    while ((busy_o || count_o != 0) && n < 100) begin tick(); n++; end
    chk("drain_idle", 32'(busy_o), 32'd0);
    chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [3:0] op, a, b;
    logic [7:0] e;
    rst_i = 1'b1; cmd_valid_i = 1'b0; rsp_ready_i = 1'b0;
    cmd_opcode_i = '0; cmd_a_i = '0; cmd_b_i = '0;
    tick(); tick();
    rst_i = 1'b0;

    // Reset state
    chk("rst_valid", 32'(rsp_valid_o), 0);
    chk("rst_count", 32'(count_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_ready", 32'(cmd_ready_o), 1);
    chk("rst_alu", 32'({alu_opcode_o, alu_a_o, alu_b_o}), 0);
    chk("rst_rsp", 32'({rsp_result_o, rsp_flags_o}), 0);

    // Single op latency: accepted at edge k, valid visible after edge k+2
    push_cmd(4'd0, 4'h7, 4'h1);
    wait_valid(cyc);
    chk("lat_edges", 32'(cyc), 32'd2);
    chk("single_result", 32'(rsp_result_o), 32'h8);
    chk("single_flags", 32'(rsp_flags_o), 32'b1001);
    chk("single_busy", 32'(busy_o), 1);
    rsp_ready_i = 1'b1; tick(); rsp_ready_i = 1'b0;
    chk("single_done_valid", 32'(rsp_valid_o), 0);
    chk("single_done_busy", 32'(busy_o), 0);

    // Zero / carry
    push_cmd(4'd0, 4'hF, 4'h1);
    wait_valid(cyc);
    chk("zc_result", 32'(rsp_result_o), 32'h0);
    chk("zc_flags", 32'(rsp_flags_o), 32'b0110);
    rsp_ready_i = 1'b1; tick(); rsp_ready_i = 1'b0;

    // Full FIFO: one in RESP, four queued, sixth refused even across a pop
    for (int i = 0; i < 5; i++) push_cmd(4'd0, 4'(i), 4'(i + 3));
    tick(); tick(); tick();
    chk("full_count", 32'(count_o), 32'd4);
    chk("full_ready", 32'(cmd_ready_o), 0);
    chk("full_rsp", 32'(rsp_valid_o), 1);
    cmd_opcode_i = 4'd1; cmd_a_i = 4'h9; cmd_b_i = 4'h2; cmd_valid_i = 1'b1;
    tick(); tick();
    chk("full_refused", 32'(count_o), 32'd4);
    rsp_ready_i = 1'b1; tick(); rsp_ready_i = 1'b0;
    chk("full_pop_no_push", 32'(count_o), 32'd3);
    tick();
    cmd_valid_i = 1'b0;
    chk("full_late_push", 32'(count_o), 32'd4);
    drain();

    // Back-to-back: response on every other cycle with ready held high
    for (int i = 0; i < 5; i++) push_cmd(4'(i % 5), 4'(i * 5), 4'(15 - i));
    tick(); tick(); tick();
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("b2b_pulse", 32'(rsp_valid_o), 32'((i % 2) == 0));
      tick();
    end
    drain();

    // Backpressure: outputs stay frozen for 5 cycles, then one acceptance
    push_cmd(4'd1, 4'h3, 4'h5);
    wait_valid(cyc);
    e = alu_ref(4'd1, 4'h3, 4'h5);
    for (int i = 0; i < 5; i++) begin
      chk("bp_result", 32'(rsp_result_o), 32'(e[3:0]));
      chk("bp_flags", 32'(rsp_flags_o), 32'(e[7:4]));
      chk("bp_alu", 32'({alu_opcode_o, alu_a_o, alu_b_o}), 32'h135);
      chk("bp_valid", 32'(rsp_valid_o), 1);
      tick();
    end
    rsp_ready_i = 1'b1; tick(); rsp_ready_i = 1'b0;
    chk("bp_accepted", 32'(rsp_valid_o), 0);
    chk("bp_sb_empty", 32'(exp_q.size()), 0);

    // Random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      cmd_valid_i  = ($urandom_range(0, 99) < 60);
      cmd_opcode_i = 4'($urandom_range(0, 15));
      cmd_a_i      = 4'($urandom_range(0, 15));
      cmd_b_i      = 4'($urandom_range(0, 15));
      rsp_ready_i  = ($urandom_range(0, 99) < 50);
      tick();
    end
    drain();

    // Reset mid-RESP with three queued: everything discarded, no stale response
    for (int i = 0; i < 4; i++) push_cmd(4'd0, 4'(i + 1), 4'(i + 2));
    tick(); tick();
    chk("pre_rst_count", 32'(count_o), 3);
    rst_i = 1'b1; tick(); tick(); rst_i = 1'b0;
    chk("mid_rst_valid", 32'(rsp_valid_o), 0);
    chk("mid_rst_count", 32'(count_o), 0);
    chk("mid_rst_busy", 32'(busy_o), 0);
    chk("mid_rst_alu_a", 32'(alu_a_o), 0);
    chk("mid_rst_ready", 32'(cmd_ready_o), 1);
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("post_rst_quiet", 32'(rsp_valid_o), 0);
      tick();
    end
    rsp_ready_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
